// File: rtl/pipe_pkg.sv
// Shared widths, opcode encoding and the ID/EX payload for the operand-fetch stage.
package pipe_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 1 << ADDR_W;
    localparam int unsigned OP_W   = 4;

    // All 16 encodings are named, so any decoded opcode casts cleanly.
    typedef enum logic [OP_W-1:0] {
        OpNop, OpAdd, OpSub, OpAnd, OpOr,  OpXor, OpShl, OpShr,
        OpLd,  OpSt,  OpMov, OpLi,  OpBeq, OpBne, OpJmp, OpHalt
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } id_ex_t;

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy bits with set-over-clear priority, plus RAW/WAW hazard detection.
module operand_scoreboard
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              use_rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wen,
    input  logic              set_en,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    output logic              h1,
    output logic              h2,
    output logic              hw,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] busy_d, busy_q;

    // A retiring producer satisfies its consumer this cycle through the bypass.
    always_comb begin
        h1 = busy_q[rs1] && !(wb_valid && wb_reg == rs1);
        h2 = use_rs2 && busy_q[rs2] && !(wb_valid && wb_reg == rs2);
        hw = wen && busy_q[rd] && !(wb_valid && wb_reg == rd);
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_reg] = 1'b0;
        if (set_en)   busy_d[rd]     = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register-file read addressing, writeback bypass, scoreboard stall
// and the ID/EX output register.
module operand_fetch
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_rs2,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [NREG-1:0]   busy_mask,
    output logic [15:0]       stall_count
);

    logic              h1, h2, hw, hazard, accept;
    logic [DATA_W-1:0] op_a, op_b;
    logic              valid_q;
    id_ex_t            id_ex_q;
    logic [15:0]       stall_q;

    assign rf_read_reg1 = in_rs1;
    assign rf_read_reg2 = in_rs2;

    // The register file only updates at the edge, so a same-cycle writeback is forwarded.
    assign op_a = (wb_valid && wb_reg == in_rs1) ? wb_data : rf_data1;
    assign op_b = (wb_valid && wb_reg == in_rs2) ? wb_data : rf_data2;

    assign hazard   = h1 || h2 || hw;
    assign in_ready = (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    operand_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .use_rs2  (in_use_rs2),
        .rd       (in_rd),
        .wen      (in_wen),
        .set_en   (accept && in_wen),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .h1       (h1),
        .h2       (h2),
        .hw       (hw),
        .busy     (busy_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_ex_q <= '0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            id_ex_q.op  <= op_e'(in_op);
            id_ex_q.rd  <= in_rd;
            id_ex_q.wen <= in_wen;
            id_ex_q.a   <= op_a;
            id_ex_q.b   <= op_b;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Only scoreboard hazards are counted; pure backpressure is not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (in_valid && hazard && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = id_ex_q.op;
    assign out_rd      = id_ex_q.rd;
    assign out_wen     = id_ex_q.wen;
    assign out_a       = id_ex_q.a;
    assign out_b       = id_ex_q.b;
    assign stall_count = stall_q;

endmodule
